dram_write_request_queue: RTL and testbench

Opposite direction of the scratchpad backend's DRAM-read → SRAM-write path. Accepts scratchpad (SRAM) read data destined for DRAM and allocates a transaction ID per request from a fixed slot pool. Issues DRAM write requests in acceptance order and holds each slot until DRAM returns a write-complete carrying that ID. Sits between the scratchpad backend SRAM read return and the DRAM write request/response channel.

---
 rtl/scpad_types_pkg.sv | 22 ++
 rtl/scpad_id_alloc.sv | 20 ++
 rtl/dram_write_request_queue.sv | 130 +++++++++++++
 tb/tb_dram_write_request_queue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpad_types_pkg.sv
// Shared scratchpad backend types, including the DRAM write-request queue
// slot states, request record and default sizing.
package scpad_types_pkg;

  localparam int DRAM_WR_NUM_IDS = 32;
  localparam int DRAM_WR_ID_W    = $clog2(DRAM_WR_NUM_IDS);
  localparam int DRAM_WR_ADDR_W  = 32;
  localparam int DRAM_WR_DATA_W  = 512;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_PENDING  = 2'd1,
    SLOT_INFLIGHT = 2'd2
  } dram_wr_slot_state_e;

  typedef struct packed {
    logic [DRAM_WR_ID_W-1:0]   id;
    logic [DRAM_WR_ADDR_W-1:0] addr;
    logic [DRAM_WR_DATA_W-1:0] data;
  } dram_wr_req_t;

endpackage

// File: rtl/scpad_id_alloc.sv
// Lowest-index free-slot priority encoder used to pick the next transaction ID.
module scpad_id_alloc #(
  parameter int N = 32,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  free_vec,
  output logic          any_free,
  output logic [IW-1:0] index
);

  always_comb begin
    any_free = |free_vec;
    index    = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/dram_write_request_queue.sv
// Buffers scratchpad read data bound for DRAM, tags each request with a slot ID,
// issues writes in acceptance order and frees a slot on its write-complete.
module dram_write_request_queue
  import scpad_types_pkg::*;
#(
  parameter int NUM_IDS = DRAM_WR_NUM_IDS,
  parameter int ADDR_W  = DRAM_WR_ADDR_W,
  parameter int DATA_W  = DRAM_WR_DATA_W,
  localparam int ID_W   = $clog2(NUM_IDS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sram_rd_valid,
  output logic              sram_rd_ready,
  input  logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              dram_wr_valid,
  input  logic              dram_wr_ready,
  output logic [ID_W-1:0]   dram_wr_id,
  output logic [ADDR_W-1:0] dram_wr_addr,
  output logic [DATA_W-1:0] dram_wr_data,
  input  logic              dram_wr_done,
  input  logic [ID_W-1:0]   dram_wr_done_id,
  output logic              queue_full,
  output logic              queue_idle,
  output logic [ID_W:0]     outstanding_cnt,
  output logic              err_spurious_done
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Valid never depends on ready; once dram_wr_valid is high the head request
  // (id/addr/data) stays stable until it is taken.

  dram_wr_slot_state_e slot_state_q [NUM_IDS];
  dram_wr_slot_state_e slot_state_d [NUM_IDS];
  logic [ADDR_W-1:0]   addr_q [NUM_IDS];
  logic [ADDR_W-1:0]   addr_d [NUM_IDS];
  logic [DATA_W-1:0]   data_q [NUM_IDS];
  logic [DATA_W-1:0]   data_d [NUM_IDS];
  logic [ID_W-1:0]     fifo_q [NUM_IDS];
  logic [ID_W-1:0]     fifo_d [NUM_IDS];
  logic [ID_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]       rd_ptr_q, rd_ptr_d;
  logic [ID_W:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_IDS-1:0]  free_vec;
  logic                any_free;
  logic [ID_W-1:0]     alloc_id;
  logic [ID_W-1:0]     head_id;
  logic                accept, issue, done_legal;

  always_comb begin
    for (int i = 0; i < NUM_IDS; i++) free_vec[i] = (slot_state_q[i] == SLOT_FREE);
  end

  scpad_id_alloc #(.N(NUM_IDS)) u_id_alloc (
    .free_vec (free_vec),
    .any_free (any_free),
    .index    (alloc_id)
  );

  assign queue_full        = (cnt_q == (ID_W+1)'(NUM_IDS));
  assign queue_idle        = (cnt_q == '0);
  assign outstanding_cnt   = cnt_q;
  assign err_spurious_done = err_q;
  assign sram_rd_ready     = !queue_full;

  assign head_id       = fifo_q[rd_ptr_q[ID_W-1:0]];
  assign dram_wr_valid = (wr_ptr_q != rd_ptr_q);
  assign dram_wr_id    = head_id;
  assign dram_wr_addr  = addr_q[head_id];
  assign dram_wr_data  = data_q[head_id];

  // any_free is redundant with !queue_full but keeps a corrupted count from
  // overwriting a busy slot.
  assign accept     = sram_rd_valid && sram_rd_ready && any_free;
  assign issue      = dram_wr_valid && dram_wr_ready;
  assign done_legal = dram_wr_done && (slot_state_q[dram_wr_done_id] == SLOT_INFLIGHT);

  always_comb begin
    slot_state_d = slot_state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    err_d        = dram_wr_done && !done_legal;
    // The three updates always touch slots in different states, so they never collide.
    if (accept) begin
      slot_state_d[alloc_id]      = SLOT_PENDING;
      addr_d[alloc_id]            = sram_rd_addr;
      data_d[alloc_id]            = sram_rd_data;
      fifo_d[wr_ptr_q[ID_W-1:0]]  = alloc_id;
      wr_ptr_d                    = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      slot_state_d[head_id] = SLOT_INFLIGHT;
      rd_ptr_d              = rd_ptr_q + 1'b1;
    end
    if (done_legal) slot_state_d[dram_wr_done_id] = SLOT_FREE;
    if (accept && !done_legal) cnt_d = cnt_q + 1'b1;
    else if (!accept && done_legal) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_state_q <= '{default: SLOT_FREE};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_state_q <= slot_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Payload storage is only read for slots that were written after reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_dram_write_request_queue.sv
// Directed bench for dram_write_request_queue: a queue/set model of the slot pool
// checked against every output on each falling clock edge, plus literal checks.
module tb_dram_write_request_queue;
  import scpad_types_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         sram_rd_valid;
  logic         sram_rd_ready;
  logic [31:0]  sram_rd_addr;
  logic [511:0] sram_rd_data;
  logic         dram_wr_valid;
  logic         dram_wr_ready;
  logic [4:0]   dram_wr_id;
  logic [31:0]  dram_wr_addr;
  logic [511:0] dram_wr_data;
  logic         dram_wr_done;
  logic [4:0]   dram_wr_done_id;
  logic         queue_full;
  logic         queue_idle;
  logic [5:0]   outstanding_cnt;
  logic         err_spurious_done;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dram_write_request_queue dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .sram_rd_valid     (sram_rd_valid),
    .sram_rd_ready     (sram_rd_ready),
    .sram_rd_addr      (sram_rd_addr),
    .sram_rd_data      (sram_rd_data),
    .dram_wr_valid     (dram_wr_valid),
    .dram_wr_ready     (dram_wr_ready),
    .dram_wr_id        (dram_wr_id),
    .dram_wr_addr      (dram_wr_addr),
    .dram_wr_data      (dram_wr_data),
    .dram_wr_done      (dram_wr_done),
    .dram_wr_done_id   (dram_wr_done_id),
    .queue_full        (queue_full),
    .queue_idle        (queue_idle),
    .outstanding_cnt   (outstanding_cnt),
    .err_spurious_done (err_spurious_done)
  );

  // ---------------- model ----------------
  dram_wr_req_t pend_q[$];      // accepted, not yet issued, in acceptance order
  bit           in_flight[N];   // issued, awaiting completion
  bit           exp_err;
  logic [4:0]   issued_q[$];    // log of issued IDs
  logic [4:0]   alloc_q[$];     // log of allocated IDs

  function automatic int n_inflight();
    int n = 0;
    for (int i = 0; i < N; i++) if (in_flight[i]) n++;
    return n;
  endfunction

  function automatic bit is_busy(int id);
    if (in_flight[id]) return 1'b1;
    foreach (pend_q[k]) if (int'(pend_q[k].id) == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    pend_q.delete();
    for (int i = 0; i < N; i++) in_flight[i] = 1'b0;
    exp_err = 1'b0;
  endfunction

  function automatic void model_update();
    int busy, alloc;
    bit acc, iss, legal;
    dram_wr_req_t r;
    if (!n_rst) begin
      model_reset();
      return;
    end
    busy  = pend_q.size() + n_inflight();
    acc   = sram_rd_valid && (busy < N);
    iss   = dram_wr_ready && (pend_q.size() > 0);
    legal = dram_wr_done && in_flight[dram_wr_done_id];
    alloc = -1;
    for (int i = N - 1; i >= 0; i--) if (!is_busy(i)) alloc = i;
    if (iss) begin
      r = pend_q.pop_front();
      in_flight[r.id] = 1'b1;
      issued_q.push_back(r.id);
    end
    if (legal) in_flight[dram_wr_done_id] = 1'b0;
    if (acc) begin
      r.id   = 5'(alloc);
      r.addr = sram_rd_addr;
      r.data = sram_rd_data;
      pend_q.push_back(r);
      alloc_q.push_back(5'(alloc));
    end
    exp_err = dram_wr_done && !legal;
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_data(string name, logic [511:0] act, logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    int busy;
    busy = pend_q.size() + n_inflight();
    chk("cnt", 64'(outstanding_cnt), 64'(busy));
    chk("full", 64'(queue_full), 64'(busy == N));
    chk("idle", 64'(queue_idle), 64'(busy == 0));
    chk("rd_ready", 64'(sram_rd_ready), 64'(busy != N));
    chk("err", 64'(err_spurious_done), 64'(exp_err));
    chk("wr_valid", 64'(dram_wr_valid), 64'(pend_q.size() > 0));
    if (pend_q.size() > 0) begin
      chk("wr_id", 64'(dram_wr_id), 64'(pend_q[0].id));
      chk("wr_addr", 64'(dram_wr_addr), 64'(pend_q[0].addr));
      chk_data("wr_data", dram_wr_data, pend_q[0].data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(logic [31:0] addr);
    sram_rd_valid = 1'b1;
    sram_rd_addr  = addr;
    sram_rd_data  = {16{addr}};
  endtask

  task automatic done_pulse(logic [4:0] id);
    dram_wr_done    = 1'b1;
    dram_wr_done_id = id;
    tick();
    dram_wr_done    = 1'b0;
  endtask

  task automatic pick_done();
    int off;
    dram_wr_done = 1'b0;
    off = $urandom_range(0, N - 1);
    if ($urandom_range(0, 1) == 1) begin
      for (int k = 0; k < N; k++) begin
        if (!dram_wr_done && in_flight[(off + k) % N]) begin
          dram_wr_done    = 1'b1;
          dram_wr_done_id = 5'((off + k) % N);
        end
      end
    end
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_valid"}, 64'(dram_wr_valid), 64'd0);
    chk({tag, "_full"}, 64'(queue_full), 64'd0);
    chk({tag, "_idle"}, 64'(queue_idle), 64'd1);
    chk({tag, "_ready"}, 64'(sram_rd_ready), 64'd1);
    chk({tag, "_cnt"}, 64'(outstanding_cnt), 64'd0);
    chk({tag, "_err"}, 64'(err_spurious_done), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, ibase;
    n_rst = 1'b0;
    sram_rd_valid = 1'b0; sram_rd_addr = '0; sram_rd_data = '0;
    dram_wr_ready = 1'b0; dram_wr_done = 1'b0; dram_wr_done_id = '0;
    model_reset();
    tick(); tick();
    n_rst = 1'b1;
    check_reset_values("rst");

    // 1: single request, immediate issue, completion
    dram_wr_ready = 1'b1;
    sram_rd_valid = 1'b1; sram_rd_addr = 32'h0000_1000; sram_rd_data = {64{8'hA5}};
    tick();
    sram_rd_valid = 1'b0;
    chk("t1_valid", 64'(dram_wr_valid), 64'd1);
    chk("t1_id", 64'(dram_wr_id), 64'd0);
    chk_data("t1_data", dram_wr_data, {64{8'hA5}});
    tick();
    chk("t1_cnt_before", 64'(outstanding_cnt), 64'd1);
    done_pulse(5'd0);
    chk("t1_cnt_after", 64'(outstanding_cnt), 64'd0);
    chk("t1_idle", 64'(queue_idle), 64'd1);

    // 2: fill with ready low, 33rd held, then drain in order
    dram_wr_ready = 1'b0;
    ibase = issued_q.size();
    for (int i = 0; i < 33; i++) begin
      set_req(32'h1000_0000 + 32'(i * 64));
      tick();
    end
    chk("t2_full", 64'(queue_full), 64'd1);
    chk("t2_ready", 64'(sram_rd_ready), 64'd0);
    chk("t2_cnt", 64'(outstanding_cnt), 64'd32);
    sram_rd_valid = 1'b0;
    dram_wr_ready = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    chk("t2_issued_n", 64'(issued_q.size() - ibase), 64'd32);
    for (int i = 0; i < 32; i++) chk("t2_order", 64'(issued_q[ibase + i]), 64'(i));
    for (int i = 31; i >= 0; i--) done_pulse(5'(i));
    chk("t2_idle", 64'(queue_idle), 64'd1);

    // 3: out-of-order completion frees lowest slots first
    for (int i = 0; i < 4; i++) begin
      set_req(32'h2000_0000 + 32'(i * 64));
      tick();
    end
    sram_rd_valid = 1'b0;
    tick();
    done_pulse(5'd2);
    done_pulse(5'd0);
    dram_wr_ready = 1'b0;
    set_req(32'h2100_0000); tick();
    set_req(32'h2100_0040); tick();
    sram_rd_valid = 1'b0;
    chk("t3_alloc_a", 64'(alloc_q[alloc_q.size() - 2]), 64'd0);
    chk("t3_alloc_b", 64'(alloc_q[alloc_q.size() - 1]), 64'd2);
    dram_wr_ready = 1'b1;
    tick(); tick();
    chk("t3_issue_a", 64'(issued_q[issued_q.size() - 2]), 64'd0);
    chk("t3_issue_b", 64'(issued_q[issued_q.size() - 1]), 64'd2);
    done_pulse(5'd0); done_pulse(5'd1); done_pulse(5'd2); done_pulse(5'd3);
    chk("t3_idle", 64'(queue_idle), 64'd1);

    // 4: random ready back-pressure over 20 requests
    base = alloc_q.size();
    ibase = issued_q.size();
    for (int c = 0; c < 200 && (alloc_q.size() - base) < 20; c++) begin
      set_req(32'h4000_0000 + 32'(c * 64));
      dram_wr_ready = 1'($urandom_range(0, 1));
      pick_done();
      tick();
    end
    sram_rd_valid = 1'b0;
    dram_wr_ready = 1'b1;
    for (int c = 0; c < 200 && (pend_q.size() + n_inflight()) > 0; c++) begin
      dram_wr_done = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!dram_wr_done && in_flight[k]) begin
          dram_wr_done = 1'b1;
          dram_wr_done_id = 5'(k);
        end
      end
      tick();
    end
    dram_wr_done = 1'b0;
    chk("t4_accepted", 64'(alloc_q.size() - base), 64'd20);
    chk("t4_issued", 64'(issued_q.size() - ibase), 64'd20);
    chk("t4_idle", 64'(queue_idle), 64'd1);

    // 5: spurious completions on FREE and PENDING slots
    done_pulse(5'd5);
    chk("t5_err_free", 64'(err_spurious_done), 64'd1);
    tick();
    chk("t5_err_clear", 64'(err_spurious_done), 64'd0);
    dram_wr_ready = 1'b0;
    set_req(32'h5000_0000); tick();
    set_req(32'h5000_0040); tick();
    sram_rd_valid = 1'b0;
    done_pulse(5'd1);
    chk("t5_err_pend", 64'(err_spurious_done), 64'd1);
    chk("t5_cnt", 64'(outstanding_cnt), 64'd2);
    tick();
    chk("t5_err_clear2", 64'(err_spurious_done), 64'd0);
    dram_wr_ready = 1'b1;
    tick(); tick();
    done_pulse(5'd0); done_pulse(5'd1);

    // 6: full queue with same-cycle done/issue/blocked accept, then async reset
    dram_wr_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_req(32'h6000_0000 + 32'(i * 64));
      tick();
    end
    sram_rd_valid = 1'b0;
    dram_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    set_req(32'h6100_0000);
    dram_wr_done = 1'b1; dram_wr_done_id = 5'd7;
    tick();
    dram_wr_done = 1'b0; dram_wr_ready = 1'b0;
    chk("t6_ready", 64'(sram_rd_ready), 64'd1);
    chk("t6_head", 64'(dram_wr_id), 64'd9);
    tick();
    sram_rd_valid = 1'b0;
    chk("t6_alloc", 64'(alloc_q[alloc_q.size() - 1]), 64'd7);
    dram_wr_ready = 1'b1;
    tick(); tick();
    #2 n_rst = 1'b0;
    model_reset();
    #1 check_reset_values("mid_rst");
    tick();
    n_rst = 1'b1;
    done_pulse(5'd3);
    chk("t6_late_done", 64'(err_spurious_done), 64'd1);
    tick();
    chk("t6_idle", 64'(queue_idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
